spi_cmd_log: RTL and testbench
==============================

SPI_CMD_LOG -- requirements
Module: spi_cmd_log

Interface
REQ-001 Parameter DEPTH, default 16; FIFO entries; power of two, 2..128.
REQ-002 Parameter CLK_PER_US, default 16; clk cycles per timestamp tick.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock (16 MHz soc clock).
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 spi_cmd_strobe  in  1  one-cycle pulse, new decoded flash command (clk domain).
REQ-007 spi_cmd  in  8  command opcode, valid with strobe.
REQ-008 spi_addr  in  32  command address, valid with strobe.
REQ-009 spi_len  in  12  transfer length, valid with strobe.
REQ-010 sel  in  1  iomem select for this block's window.
REQ-011 addr  in  8  iomem byte offset.
REQ-012 wstrb  in  4  iomem byte write strobes; 0 = read.
REQ-013 wdata  in  32  iomem write data.
REQ-014 rdata  out  32  iomem read data.
REQ-015 ready  out  1  iomem acknowledge.
REQ-016 log_nonempty  out  1  FIFO holds at least one entry (LED/irq use).

Function
REQ-017 Free-running timebase: prescaler counts 0..CLK_PER_US-1; 24-bit tick counter increments on prescaler wrap and wraps modulo 2^24.
REQ-018 On spi_cmd_strobe with capture enabled and FIFO not full: push entry {tick[23:0], cmd, addr, len} (76 bits), sampled in the strobe cycle.
REQ-019 Strobe while full: entry dropped; dropped counter +1, saturating at 16'hFFFF.
REQ-020 Strobe with capture disabled: ignored, dropped counter unchanged.
REQ-021 Push visible in STATUS/head registers on a read issued in the cycle after the strobe or later.
REQ-022 ready = sel && !ready, registered: one-cycle pulse one cycle after sel; rdata valid with ready; re-arms after a cycle of ready.
REQ-023 All side effects (pop, CTRL write) execute exactly once, in the cycle ready is driven high.
REQ-024 0x00 STATUS (RO): [7:0] level, [8] empty, [9] full, [15:10] 0, [31:16] dropped count.
REQ-025 0x04 HEAD_CMD (RO): {tick, cmd} of head entry; 0 when empty.
REQ-026 0x08 HEAD_ADDR (RO): head addr; 0 when empty.
REQ-027 0x0C HEAD_LEN (RO): {20'h0, len}; 0 when empty.
REQ-028 0x10 POP: any write (wstrb != 0) removes head; ignored when empty; reads return 0.
REQ-029 0x14 CTRL: bit0 capture enable (RW); bit1 write-1 flush (self-clearing, reads 0): empties FIFO and zeroes dropped count.
REQ-030 Unmapped offsets: reads return 32'hDECAFBAD, writes ignored.
REQ-031 Push and pop same cycle: both occur, level unchanged; pop when level 1 plus push leaves the new entry at head.
REQ-032 Push into empty FIFO and head read completing same cycle: read returns empty values (0).
REQ-033 Flush and strobe same cycle: flush wins; strobe discarded, not counted as dropped.
REQ-034 Pointers wrap modulo DEPTH; level saturates at DEPTH (full) and never exceeds it.
REQ-035 log_nonempty = !empty, combinational from level.

Reset
REQ-036 On resetn low, asynchronously: FIFO empty, pointers 0, dropped 0, prescaler and tick 0, capture enable 1, ready 0, rdata 0, log_nonempty 0.
REQ-037 Reset mid-access: transaction abandoned, no pop, no ready pulse after release until a new sel.
REQ-038 FIFO storage contents are not reset; empty flag masks them.

Structure
REQ-039 Shared header spi_cmd_log_defs.vh: register offsets, ENTRY_W = 76, field bit positions, DECAFBAD default.
REQ-040 One sub-module spi_log_fifo: synchronous FIFO, push/pop/flush, level/full/empty, first-word-fall-through head; inferable as iCE40 BRAM.
REQ-041 Timebase, register decode and iomem handshake live in spi_cmd_log.

Verification
REQ-042 Reset, read 0x00 -> 0x00000100 (level 0, empty); read 0x14 -> 0x00000001.
REQ-043 Strobe cmd 0x03, addr 0x00123456, len 0x010 at tick 5 -> STATUS 0x00000001; HEAD_CMD 0x00000503; HEAD_ADDR 0x00123456; HEAD_LEN 0x00000010; write 0x10 -> STATUS 0x00000100.
REQ-044 17 strobes, DEPTH 16 -> STATUS 0x00010210 (level 16, full, dropped 1); head = first command.
REQ-045 Pop write coincident with strobe at level 3 -> level stays 3; head advances to second entry.
REQ-046 Write 0x14 = 0x2 with full FIFO, dropped 5, strobe same cycle -> STATUS 0x00000100, CTRL reads 0x1.
REQ-047 Write 0x14 = 0, then strobe -> level 0, dropped 0; read 0x20 -> 0xDECAFBAD; ready high exactly one cycle per access.

Source files
------------

// File: rtl/spi_cmd_log_pkg.sv
// Shared definitions for the SPI command logger: register map, log entry layout, defaults.
package spi_cmd_log_pkg;

    // Log entry: {tick[23:0], cmd[7:0], addr[31:0], len[11:0]}, 76 bits, tick in the MSBs.
    typedef struct packed {
        logic [23:0] tick;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [11:0] len;
    } log_entry_t;

    localparam int ENTRY_W = $bits(log_entry_t);

    localparam logic [7:0] REG_STATUS    = 8'h00;
    localparam logic [7:0] REG_HEAD_CMD  = 8'h04;
    localparam logic [7:0] REG_HEAD_ADDR = 8'h08;
    localparam logic [7:0] REG_HEAD_LEN  = 8'h0C;
    localparam logic [7:0] REG_POP       = 8'h10;
    localparam logic [7:0] REG_CTRL      = 8'h14;

    localparam int CTRL_CAPTURE_BIT = 0;
    localparam int CTRL_FLUSH_BIT   = 1;

    localparam logic [31:0] RDATA_UNMAPPED = 32'hDECAFBAD;

endpackage

// File: rtl/spi_cmd_log_fifo.sv
// First-word-fall-through synchronous FIFO; storage uses a registered read so it maps to block RAM.
module spi_log_fifo
    import spi_cmd_log_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] mem_q;
    logic [WIDTH-1:0] byp_data;
    logic             byp_sel;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_addr_next;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == LEVEL_FULL);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        rd_addr_next = rd_ptr;
        if (flush) begin
            rd_addr_next = '0;
        end else if (pop_ok) begin
            rd_addr_next = rd_ptr + AW'(1);
        end
    end

    // The RAM read is prefetched at the next head address; a write landing on that
    // same address this cycle is forwarded through the bypass register instead.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
        mem_q    <= mem[rd_addr_next];
        byp_data <= wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            byp_sel <= 1'b0;
        end else begin
            byp_sel <= push_ok && (wr_ptr == rd_addr_next);
            rd_ptr  <= rd_addr_next;
            if (flush) begin
                wr_ptr <= '0;
                level  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                case ({push_ok, pop_ok})
                    2'b10:   level <= level + (AW + 1)'(1);
                    2'b01:   level <= level - (AW + 1)'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    assign head = byp_sel ? byp_data : mem_q;

endmodule

// File: rtl/spi_cmd_log.sv
// SPI flash command logger: timestamps decoded commands into a FIFO that software drains over iomem.
module spi_cmd_log
    import spi_cmd_log_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int CLK_PER_US = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        spi_cmd_strobe,
    input  logic [7:0]  spi_cmd,
    input  logic [31:0] spi_addr,
    input  logic [11:0] spi_len,
    input  logic        sel,
    input  logic [7:0]  addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        log_nonempty
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_US - 1);

    logic [PW-1:0] presc;
    logic [23:0]   tick;
    logic          capture_en;
    logic [15:0]   dropped;
    logic          blocked;
    logic          access;
    logic          ctrl_wr;
    logic          flush;
    logic          pop_req;
    logic          strobe_live;
    logic          push;
    logic          drop;
    log_entry_t    new_entry;
    log_entry_t    head_entry;
    logic [LW-1:0] fifo_level;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    level8;
    logic [31:0]   rd_mux;
    logic          unused_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
            tick  <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            tick  <= tick + 24'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Handshake: sel is the request and is held until ready. ready is high for exactly one
    // cycle, registered one clock after sel is seen with ready low; rdata is valid and all
    // side effects have been applied on that same edge. A sel held across reset is abandoned
    // and only a fresh sel (after sel has been low) starts a new access.
    assign access  = sel && !ready && !blocked;
    assign ctrl_wr = access && (addr == REG_CTRL) && wstrb[0];
    assign flush   = ctrl_wr && wdata[CTRL_FLUSH_BIT];
    assign pop_req = access && (addr == REG_POP) && (wstrb != 4'h0);

    assign strobe_live = spi_cmd_strobe && capture_en && !flush;
    assign push        = strobe_live && !fifo_full;
    assign drop        = strobe_live && fifo_full;

    assign new_entry = '{tick: tick, cmd: spi_cmd, addr: spi_addr, len: spi_len};

    spi_log_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop_req),
        .flush  (flush),
        .wdata  (new_entry),
        .head   (head_entry),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // A flush write only flushes; the capture enable is changed by writes with the flush bit clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            capture_en <= 1'b1;
            dropped    <= '0;
        end else begin
            if (ctrl_wr && !wdata[CTRL_FLUSH_BIT]) begin
                capture_en <= wdata[CTRL_CAPTURE_BIT];
            end
            if (flush) begin
                dropped <= '0;
            end else if (drop && (dropped != 16'hFFFF)) begin
                dropped <= dropped + 16'd1;
            end
        end
    end

    assign level8       = 8'(fifo_level);
    assign log_nonempty = !fifo_empty;
    assign unused_wdata = ^wdata[31:2];

    always_comb begin
        rd_mux = RDATA_UNMAPPED;
        case (addr)
            REG_STATUS:    rd_mux = {dropped, 6'b0, fifo_full, fifo_empty, level8};
            REG_HEAD_CMD:  rd_mux = fifo_empty ? 32'h0 : {head_entry.tick, head_entry.cmd};
            REG_HEAD_ADDR: rd_mux = fifo_empty ? 32'h0 : head_entry.addr;
            REG_HEAD_LEN:  rd_mux = fifo_empty ? 32'h0 : {20'h0, head_entry.len};
            REG_POP:       rd_mux = 32'h0;
            REG_CTRL:      rd_mux = {31'h0, capture_en};
            default:       rd_mux = RDATA_UNMAPPED;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready   <= 1'b0;
            rdata   <= '0;
            blocked <= 1'b1;
        end else begin
            ready <= access;
            if (access) begin
                rdata <= rd_mux;
            end
            if (!sel) begin
                blocked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_log.sv
// Directed bench for spi_cmd_log: register map, FIFO ordering, overflow, flush, reset behaviour.
module tb_spi_cmd_log;
    localparam int DEPTH      = 16;
    localparam int CLK_PER_US = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        spi_cmd_strobe = 1'b0;
    logic [7:0]  spi_cmd = '0;
    logic [31:0] spi_addr = '0;
    logic [11:0] spi_len = '0;
    logic        sel = 1'b0;
    logic [7:0]  addr = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        log_nonempty;

    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned bcyc;
    logic [23:0] last_tick;

    spi_cmd_log #(
        .DEPTH      (DEPTH),
        .CLK_PER_US (CLK_PER_US)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .spi_cmd_strobe (spi_cmd_strobe),
        .spi_cmd        (spi_cmd),
        .spi_addr       (spi_addr),
        .spi_len        (spi_len),
        .sel            (sel),
        .addr           (addr),
        .wstrb          (wstrb),
        .wdata          (wdata),
        .rdata          (rdata),
        .ready          (ready),
        .log_nonempty   (log_nonempty)
    );

    always #5 clk = ~clk;

    // Reference timebase: clock edges since reset release; tick = bcyc / CLK_PER_US.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) bcyc <= 0;
        else         bcyc <= bcyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic load_cmd(input logic [7:0] c, input logic [31:0] a, input logic [11:0] l);
        spi_cmd  = c;
        spi_addr = a;
        spi_len  = l;
    endtask

    // One iomem access; optionally pulses the command strobe in the cycle the access completes.
    task automatic access(input logic [7:0] a, input logic [3:0] ws, input logic [31:0] wd,
                          input bit with_strobe, output logic [31:0] rd);
        int waited;
        @(negedge clk);
        sel   = 1'b1;
        addr  = a;
        wstrb = ws;
        wdata = wd;
        if (with_strobe) begin
            spi_cmd_strobe = 1'b1;
            last_tick = 24'(bcyc / CLK_PER_US);
        end
        waited = 0;
        do begin
            @(negedge clk);
            spi_cmd_strobe = 1'b0;
            waited++;
        end while (!ready && waited < 8);
        check("ready_ack", 32'(ready), 32'd1);
        rd    = rdata;
        sel   = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        access(a, 4'h0, 32'h0, 1'b0, r);
        check(tag, r, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        access(a, 4'hF, d, 1'b0, r);
    endtask

    task automatic strobe(input logic [7:0] c, input logic [31:0] a, input logic [11:0] l);
        @(negedge clk);
        load_cmd(c, a, l);
        spi_cmd_strobe = 1'b1;
        last_tick = 24'(bcyc / CLK_PER_US);
        @(negedge clk);
        spi_cmd_strobe = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [23:0] t_first, t_a, t_b, t_d, t_e, t_f;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_nonempty", 32'(log_nonempty), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        rd_chk(8'h00, 32'h0000_0100, "status_after_reset");
        rd_chk(8'h14, 32'h0000_0001, "ctrl_after_reset");

        // Single entry captured at tick 5
        while (bcyc < 84) @(negedge clk);
        strobe(8'h03, 32'h0012_3456, 12'h010);
        check("nonempty_after_push", 32'(log_nonempty), 32'd1);
        rd_chk(8'h00, 32'h0000_0001, "status_one");
        rd_chk(8'h04, 32'h0000_0503, "head_cmd_tick5");
        rd_chk(8'h08, 32'h0012_3456, "head_addr");
        rd_chk(8'h0C, 32'h0000_0010, "head_len");
        rd_chk(8'h10, 32'h0000_0000, "pop_reads_zero");
        wr(8'h10, 32'h0);
        rd_chk(8'h00, 32'h0000_0100, "status_after_pop");
        check("nonempty_after_pop", 32'(log_nonempty), 32'd0);

        // Overflow: 17 strobes into 16 entries, then 4 more
        for (int i = 0; i < 17; i++) begin
            strobe(8'(8'h20 + i), 32'hA000_0000 + 32'(i), 12'(i + 1));
            if (i == 0) t_first = last_tick;
        end
        rd_chk(8'h00, 32'h0001_0210, "status_full_drop1");
        rd_chk(8'h04, {t_first, 8'h20}, "head_cmd_first");
        rd_chk(8'h08, 32'hA000_0000, "head_addr_first");
        rd_chk(8'h0C, 32'h0000_0001, "head_len_first");
        for (int i = 0; i < 4; i++) strobe(8'h30, 32'h0, 12'h0);
        rd_chk(8'h00, 32'h0005_0210, "status_full_drop5");

        // Flush with a coincident strobe: flush wins
        load_cmd(8'h77, 32'h7777_7777, 12'h777);
        access(8'h14, 4'hF, 32'h2, 1'b1, r);
        rd_chk(8'h00, 32'h0000_0100, "status_after_flush");
        rd_chk(8'h14, 32'h0000_0001, "ctrl_after_flush");

        // Pop coincident with push at level 3
        strobe(8'h41, 32'hB000_0001, 12'h011); t_a = last_tick;
        strobe(8'h42, 32'hB000_0002, 12'h022); t_b = last_tick;
        strobe(8'h43, 32'hB000_0003, 12'h033);
        rd_chk(8'h00, 32'h0000_0003, "status_three");
        rd_chk(8'h04, {t_a, 8'h41}, "head_cmd_a");
        load_cmd(8'h44, 32'hB000_0004, 12'h044);
        access(8'h10, 4'hF, 32'h0, 1'b1, r); t_d = last_tick;
        rd_chk(8'h00, 32'h0000_0003, "status_pop_push_3");
        rd_chk(8'h04, {t_b, 8'h42}, "head_cmd_b");
        rd_chk(8'h08, 32'hB000_0002, "head_addr_b");

        // Pop coincident with push at level 1: new entry becomes head
        wr(8'h10, 32'h0);
        wr(8'h10, 32'h0);
        rd_chk(8'h00, 32'h0000_0001, "status_one_left");
        rd_chk(8'h04, {t_d, 8'h44}, "head_cmd_d");
        load_cmd(8'h45, 32'hB000_0005, 12'h055);
        access(8'h10, 4'hF, 32'h0, 1'b1, r); t_e = last_tick;
        rd_chk(8'h00, 32'h0000_0001, "status_pop_push_1");
        rd_chk(8'h04, {t_e, 8'h45}, "head_cmd_e");
        rd_chk(8'h0C, 32'h0000_0055, "head_len_e");

        // Head read completing in the same cycle as a push into an empty FIFO
        wr(8'h10, 32'h0);
        load_cmd(8'h46, 32'hB000_0006, 12'h066);
        access(8'h04, 4'h0, 32'h0, 1'b1, r); t_f = last_tick;
        check("head_read_same_cycle_push", r, 32'h0);
        rd_chk(8'h00, 32'h0000_0001, "status_after_same_cycle");
        rd_chk(8'h04, {t_f, 8'h46}, "head_cmd_f");
        wr(8'h10, 32'h0);
        wr(8'h10, 32'h0);
        rd_chk(8'h00, 32'h0000_0100, "status_pop_on_empty");

        // Capture disabled, unmapped offsets, one-cycle ready
        wr(8'h14, 32'h0);
        rd_chk(8'h14, 32'h0000_0000, "ctrl_disabled");
        strobe(8'h50, 32'hC000_0000, 12'h0AA);
        rd_chk(8'h00, 32'h0000_0100, "status_capture_off");
        wr(8'h20, 32'h1234_5678);
        rd_chk(8'h20, 32'hDECA_FBAD, "unmapped_read");
        @(negedge clk);
        check("ready_one_cycle", 32'(ready), 32'd0);

        // Reset in the middle of an access
        wr(8'h14, 32'h1);
        strobe(8'h60, 32'hD000_0000, 12'h001);
        wr(8'h14, 32'h0);
        rd_chk(8'h00, 32'h0000_0001, "status_before_mid_reset");
        @(negedge clk);
        sel   = 1'b1;
        addr  = 8'h10;
        wstrb = 4'hF;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_reset_no_ready", 32'(ready), 32'd0);
        end
        check("mid_reset_rdata", rdata, 32'h0);
        sel   = 1'b0;
        wstrb = 4'h0;
        rd_chk(8'h00, 32'h0000_0100, "status_after_mid_reset");
        rd_chk(8'h14, 32'h0000_0001, "ctrl_after_mid_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
